// File: rtl/memref_pkg.sv
// Shared types, limits and helpers for the memref_mp multi-port memory model.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   rd_mode_t      - read/write collision policy selector
//   STAT_W         - width of every statistics counter
//   MAX_RD_PORTS   - upper bound on RD_PORTS
//   MAX_RD_LATENCY - upper bound on RD_LATENCY
//   sat_inc()      - saturating counter increment
package memref_pkg;

    // RD_FIRST: a colliding read returns the word as it was before the write.
    // WR_FIRST: a colliding read returns the word with the write merged in.
    typedef enum logic {
        RD_FIRST = 1'b0,
        WR_FIRST = 1'b1
    } rd_mode_t;

    localparam int STAT_W         = 32;
    localparam int MAX_RD_PORTS   = 8;
    localparam int MAX_RD_LATENCY = 4;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/memref_rd_pipe.sv
// Read-data delay line for one memref_mp read port.
// Latency: RD_LATENCY cycles from in_vld to out_vld.
// Backpressure: none; accepts one sample per cycle, so throughput is 1/cycle.
//
// Ports:
//   clk, rst          - clock, synchronous active-low clear of every stage
//   in_vld, in_dat    - sample taken at the request edge
//   out_vld, out_dat  - delayed sample; out_dat holds its last value while
//                       out_vld is low and is 0 after reset
module memref_rd_pipe
    import memref_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_chk_latency
        $error("memref_rd_pipe: RD_LATENCY out of range");
    end

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]      dat_q [RD_LATENCY];
    logic [WIDTH-1:0]      dat_d [RD_LATENCY];

    // Data stages only load when a valid sample moves into them, so the
    // last stage naturally holds the most recent returned word between
    // valids.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_vld;
        dat_d[0] = in_vld ? in_dat : dat_q[0];
        for (int k = 1; k < RD_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
        end
    end

    // Clearing every stage drops reads that are in flight at reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < RD_LATENCY; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    assign out_vld = vld_q[RD_LATENCY-1];
    assign out_dat = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/memref_mp.sv
// Multi-port memory model: RD_PORTS read ports, one byte-enabled write port.
// Latency: read data valid RD_LATENCY cycles after rd_en; writes visible to reads issued on the next edge.
// Backpressure: none; every port accepts one request per cycle unconditionally.
//
// Ports:
//   clk, rst                 - clock, synchronous active-low reset (memory contents survive reset)
//   rd_en/rd_addr            - per-port read request, address slice i belongs to port i
//   rd_valid/rd_data         - per-port returned word (0 for out-of-range addresses)
//   wr_en/wr_be/wr_addr/wr_data - write request with per-byte enables
//   err_clr                  - clears the sticky error flags (a same-cycle new error still sets)
//   err_rd_oob/err_wr_oob    - sticky out-of-range flags
//   stat_rd_count/stat_wr_count - saturating request counters, out-of-range included
//
// Build option: MEMREF_MP_STATS_EN enables the counters; without it the stat
// ports stay present and read as 0.
module memref_mp
    import memref_pkg::*;
#(
    parameter int       WIDTH      = 32,
    parameter int       SIZE       = 1024,
    parameter int       ADDR_W     = $clog2(SIZE) + 1,
    parameter int       RD_PORTS   = 2,
    parameter int       RD_LATENCY = 1,
    parameter rd_mode_t RD_MODE    = RD_FIRST,
    parameter string    INIT_FILE  = ""
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RD_PORTS-1:0]        rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS-1:0]        rd_valid,
    output logic [RD_PORTS*WIDTH-1:0]  rd_data,
    input  logic                       wr_en,
    input  logic [WIDTH/8-1:0]         wr_be,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       err_clr,
    output logic [RD_PORTS-1:0]        err_rd_oob,
    output logic                       err_wr_oob,
    output logic [RD_PORTS*STAT_W-1:0] stat_rd_count,
    output logic [STAT_W-1:0]          stat_wr_count
);

    localparam int                NBYTES = WIDTH / 8;
    localparam int                IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(SIZE);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_chk_width
        $error("memref_mp: WIDTH must be a positive multiple of 8");
    end
    if (RD_PORTS < 1 || RD_PORTS > MAX_RD_PORTS) begin : g_chk_ports
        $error("memref_mp: RD_PORTS out of range");
    end
    // The address must be wide enough to index every word and still leave
    // room to express SIZE itself, otherwise the range check is meaningless.
    if (ADDR_W < IDX_W || (SIZE >> ADDR_W) != 0) begin : g_chk_addr
        $error("memref_mp: ADDR_W too narrow for SIZE");
    end

    // ------------------------------------------------------------------
    // Storage. Deliberately not reset: contents must survive rst.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [SIZE];

    logic wr_oob;
    logic wr_ok;

    assign wr_oob = (wr_addr >= SIZE_A);
    // A write in the reset cycle is discarded along with everything else.
    assign wr_ok  = rst && wr_en && !wr_oob;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr[IDX_W-1:0]][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read sampling and collision handling
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   rd_a    [RD_PORTS];
    logic [WIDTH-1:0]    rd_word [RD_PORTS];
    logic [RD_PORTS-1:0] rd_oob;

    // The array read is taken before this edge's write lands, which is the
    // RD_FIRST behaviour by construction. WR_FIRST overlays the enabled
    // write bytes onto the sampled word instead.
    always_comb begin
        rd_oob = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_a[i]    = rd_addr[i*ADDR_W +: ADDR_W];
            rd_oob[i]  = (rd_a[i] >= SIZE_A);
            rd_word[i] = mem[rd_a[i][IDX_W-1:0]];
            if (RD_MODE == WR_FIRST && wr_ok && (wr_addr == rd_a[i])) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (wr_be[k]) begin
                        rd_word[i][k*8 +: 8] = wr_data[k*8 +: 8];
                    end
                end
            end
            // Out-of-range reads still complete, but with a zero word.
            if (rd_oob[i]) begin
                rd_word[i] = '0;
            end
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        memref_rd_pipe #(
            .WIDTH      (WIDTH),
            .RD_LATENCY (RD_LATENCY)
        ) u_pipe (
            .clk     (clk),
            .rst     (rst),
            .in_vld  (rd_en[i]),
            .in_dat  (rd_word[i]),
            .out_vld (rd_valid[i]),
            .out_dat (rd_data[i*WIDTH +: WIDTH])
        );
    end

    // ------------------------------------------------------------------
    // Sticky error flags. Clear is applied first and new errors OR'd in
    // afterwards, so an error coincident with err_clr survives.
    // ------------------------------------------------------------------
    logic [RD_PORTS-1:0] err_rd_oob_q, err_rd_oob_d;
    logic                err_wr_oob_q, err_wr_oob_d;

    always_comb begin
        err_rd_oob_d = (err_clr ? '0 : err_rd_oob_q) | (rd_en & rd_oob);
        err_wr_oob_d = (err_clr ? 1'b0 : err_wr_oob_q) | (wr_en & wr_oob);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_rd_oob_q <= '0;
            err_wr_oob_q <= 1'b0;
        end else begin
            err_rd_oob_q <= err_rd_oob_d;
            err_wr_oob_q <= err_wr_oob_d;
        end
    end

    assign err_rd_oob = err_rd_oob_q;
    assign err_wr_oob = err_wr_oob_q;

    // ------------------------------------------------------------------
    // Request counters. Every request counts, including zero-byte-enable
    // writes and out-of-range accesses.
    // ------------------------------------------------------------------
`ifdef MEMREF_MP_STATS_EN
    logic [STAT_W-1:0] rd_cnt_q [RD_PORTS];
    logic [STAT_W-1:0] rd_cnt_d [RD_PORTS];
    logic [STAT_W-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_cnt_d[i] = rd_en[i] ? sat_inc(rd_cnt_q[i]) : rd_cnt_q[i];
        end
        wr_cnt_d = wr_en ? sat_inc(wr_cnt_q) : wr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RD_PORTS; i++) begin
                rd_cnt_q[i] <= '0;
            end
            wr_cnt_q <= '0;
        end else begin
            for (int i = 0; i < RD_PORTS; i++) begin
                rd_cnt_q[i] <= rd_cnt_d[i];
            end
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_comb begin
        stat_rd_count = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            stat_rd_count[i*STAT_W +: STAT_W] = rd_cnt_q[i];
        end
    end

    assign stat_wr_count = wr_cnt_q;
`else
    assign stat_rd_count = '0;
    assign stat_wr_count = '0;
`endif

endmodule

// File: tb/tb_memref_mp.sv
// Bench for memref_mp: two instances (RD_FIRST latency 2, WR_FIRST latency 3)
// share one stimulus stream; a queue-based reference model predicts each
// port's returned words, error flags and counters every cycle.
module tb_memref_mp;
    import memref_pkg::*;

    localparam int W    = 32;
    localparam int SIZE = 1024;
    localparam int AW   = 11;
    localparam int NP   = 2;
    localparam int NI   = 2;
    localparam int LAT0 = 2;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NP-1:0]    rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic             wr_en;
    logic [3:0]       wr_be;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic             err_clr;

    logic [NP-1:0]    rd_valid_o [NI];
    logic [NP*W-1:0]  rd_data_o  [NI];
    logic [NP-1:0]    err_rd_o   [NI];
    logic             err_wr_o   [NI];
    logic [NP*32-1:0] stat_rd_o  [NI];
    logic [31:0]      stat_wr_o  [NI];

    memref_mp #(.WIDTH(W), .SIZE(SIZE), .ADDR_W(AW), .RD_PORTS(NP),
                .RD_LATENCY(LAT0), .RD_MODE(RD_FIRST), .INIT_FILE("")) u_rdf (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid_o[0]), .rd_data(rd_data_o[0]),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_clr(err_clr), .err_rd_oob(err_rd_o[0]), .err_wr_oob(err_wr_o[0]),
        .stat_rd_count(stat_rd_o[0]), .stat_wr_count(stat_wr_o[0]));

    memref_mp #(.WIDTH(W), .SIZE(SIZE), .ADDR_W(AW), .RD_PORTS(NP),
                .RD_LATENCY(LAT1), .RD_MODE(WR_FIRST), .INIT_FILE("")) u_wrf (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid_o[1]), .rd_data(rd_data_o[1]),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_clr(err_clr), .err_rd_oob(err_rd_o[1]), .err_wr_oob(err_wr_o[1]),
        .stat_rd_count(stat_rd_o[1]), .stat_wr_count(stat_wr_o[1]));

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    exp_t        expq [NI*NP][$];
    logic [31:0] last_dat [NI*NP];
    logic [31:0] mdl_mem [SIZE];
    logic [NP-1:0] mdl_err_rd;
    logic        mdl_err_wr;
    logic [31:0] mdl_rd_cnt [NP];
    logic [31:0] mdl_wr_cnt;
    int          edge_n;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(15) == 0) return AW'(SIZE + $urandom_range(63));
        return AW'($urandom_range(63));
    endfunction

    task automatic model_edge();
        logic [NP-1:0] new_rd;
        logic          new_wr;
        logic [AW-1:0] a;
        logic [31:0]   v0, v1;
        exp_t          e;
        edge_n++;
        if (!rst) begin
            for (int i = 0; i < NI*NP; i++) begin
                expq[i].delete();
                last_dat[i] = '0;
            end
            mdl_err_rd = '0;
            mdl_err_wr = 1'b0;
            for (int p = 0; p < NP; p++) mdl_rd_cnt[p] = '0;
            mdl_wr_cnt = '0;
            return;
        end
        new_rd = '0;
        new_wr = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (rd_en[p]) begin
                a = rd_addr[p*AW +: AW];
                if (int'(a) >= SIZE) begin
                    v0 = '0; v1 = '0; new_rd[p] = 1'b1;
                end else begin
                    v0 = mdl_mem[a[9:0]];
                    v1 = (wr_en && wr_addr == a) ? merge(v0, wr_data, wr_be) : v0;
                end
                e.due = edge_n + LAT0 - 1; e.dat = v0; expq[p].push_back(e);
                e.due = edge_n + LAT1 - 1; e.dat = v1; expq[NP+p].push_back(e);
                if (mdl_rd_cnt[p] != 32'hFFFF_FFFF) mdl_rd_cnt[p]++;
            end
        end
        if (wr_en) begin
            if (int'(wr_addr) >= SIZE) new_wr = 1'b1;
            else mdl_mem[wr_addr[9:0]] = merge(mdl_mem[wr_addr[9:0]], wr_data, wr_be);
            if (mdl_wr_cnt != 32'hFFFF_FFFF) mdl_wr_cnt++;
        end
        mdl_err_rd = (err_clr ? '0 : mdl_err_rd) | new_rd;
        mdl_err_wr = (err_clr ? 1'b0 : mdl_err_wr) | new_wr;
    endtask

    task automatic check_all();
        exp_t e;
        logic ev;
        int   idx;
        for (int m = 0; m < NI; m++) begin
            for (int p = 0; p < NP; p++) begin
                idx = m*NP + p;
                ev  = 1'b0;
                if (expq[idx].size() != 0 && expq[idx][0].due == edge_n) begin
                    e = expq[idx].pop_front();
                    ev = 1'b1;
                    last_dat[idx] = e.dat;
                end
                chk($sformatf("rd_valid[%0d][%0d]@%0d", m, p, edge_n), 64'(rd_valid_o[m][p]), 64'(ev));
                chk($sformatf("rd_data[%0d][%0d]@%0d", m, p, edge_n), 64'(rd_data_o[m][p*W +: W]), 64'(last_dat[idx]));
                chk($sformatf("err_rd_oob[%0d][%0d]@%0d", m, p, edge_n), 64'(err_rd_o[m][p]), 64'(mdl_err_rd[p]));
`ifdef MEMREF_MP_STATS_EN
                chk($sformatf("stat_rd[%0d][%0d]@%0d", m, p, edge_n), 64'(stat_rd_o[m][p*32 +: 32]), 64'(mdl_rd_cnt[p]));
`else
                chk($sformatf("stat_rd[%0d][%0d]@%0d", m, p, edge_n), 64'(stat_rd_o[m][p*32 +: 32]), 64'd0);
`endif
            end
            chk($sformatf("err_wr_oob[%0d]@%0d", m, edge_n), 64'(err_wr_o[m]), 64'(mdl_err_wr));
`ifdef MEMREF_MP_STATS_EN
            chk($sformatf("stat_wr[%0d]@%0d", m, edge_n), 64'(stat_wr_o[m]), 64'(mdl_wr_cnt));
`else
            chk($sformatf("stat_wr[%0d]@%0d", m, edge_n), 64'(stat_wr_o[m]), 64'd0);
`endif
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are compared then too.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        rd_en   = '0;
        wr_en   = 1'b0;
        wr_be   = '0;
        err_clr = 1'b0;
    endtask

    // Issue one read (plus any write the caller has set up) and report the
    // latency and word seen on each instance.
    task automatic read_watch(input string tag, input int p, input logic [AW-1:0] a,
                              input logic [31:0] e0, input logic [31:0] e1);
        int          seen [NI];
        logic [31:0] got  [NI];
        for (int m = 0; m < NI; m++) begin seen[m] = 0; got[m] = '0; end
        rd_en = '0;
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
        step();
        idle();
        for (int n = 1; n <= 5; n++) begin
            if (n > 1) step();
            for (int m = 0; m < NI; m++) begin
                if (rd_valid_o[m][p] && seen[m] == 0) begin
                    seen[m] = n;
                    got[m]  = rd_data_o[m][p*W +: W];
                end
            end
        end
        chk({tag, "_lat_rdfirst"}, 64'(seen[0]), 64'(LAT0));
        chk({tag, "_lat_wrfirst"}, 64'(seen[1]), 64'(LAT1));
        chk({tag, "_dat_rdfirst"}, 64'(got[0]), 64'(e0));
        chk({tag, "_dat_wrfirst"}, 64'(got[1]), 64'(e1));
    endtask

    initial begin
        int vcnt [NI*NP];
        int first_v [NI*NP];
        int last_v [NI*NP];
        int nv;

        rst = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        idle();
        edge_n = 0;
        for (int a = 0; a < SIZE; a++) mdl_mem[a] = '0;

        // Reset state
        step();
        step();
        rst = 1'b1;

        // Fill the low 64 words so every later read has a known value
        for (int a = 0; a < 64; a++) begin
            wr_en = 1'b1; wr_be = 4'hF; wr_addr = AW'(a); wr_data = $urandom;
            step();
        end
        idle();

        // Basic read/write
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 11'd5; wr_data = 32'hDEADBEEF;
        step();
        idle();
        step();
        read_watch("basic", 1, 11'd5, 32'hDEADBEEF, 32'hDEADBEEF);

        // Collision
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 11'd7; wr_data = 32'h11111111;
        step();
        idle();
        wr_en = 1'b1; wr_be = 4'h3; wr_addr = 11'd7; wr_data = 32'hAABBCCDD;
        read_watch("coll", 0, 11'd7, 32'h11111111, 32'h1111CCDD);
        read_watch("coll_after", 0, 11'd7, 32'h1111CCDD, 32'h1111CCDD);

        // Out of range
        read_watch("oob_rd", 0, 11'd1030, 32'h0, 32'h0);
        for (int m = 0; m < NI; m++) chk($sformatf("oob_rd_flag[%0d]", m), 64'(err_rd_o[m][0]), 64'd1);
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 11'd2000; wr_data = 32'hFFFFFFFF;
        step();
        wr_addr = 11'd1029;   // low bits alias address 5
        step();
        idle();
        for (int m = 0; m < NI; m++) chk($sformatf("oob_wr_flag[%0d]", m), 64'(err_wr_o[m]), 64'd1);
        read_watch("oob_wr_untouched", 0, 11'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        err_clr = 1'b1;
        step();
        idle();
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("clr_rd_flag[%0d]", m), 64'(err_rd_o[m]), 64'd0);
            chk($sformatf("clr_wr_flag[%0d]", m), 64'(err_wr_o[m]), 64'd0);
        end
        err_clr = 1'b1; rd_en = 2'b01; rd_addr[0 +: AW] = 11'd1030;
        step();
        idle();
        for (int m = 0; m < NI; m++) chk($sformatf("clr_vs_new[%0d]", m), 64'(err_rd_o[m][0]), 64'd1);
        for (int n = 0; n < 4; n++) step();

        // Reset one cycle after a read is issued
        rd_en = 2'b10; rd_addr[AW +: AW] = 11'd5;
        step();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("rst_valid[%0d]", m), 64'(rd_valid_o[m]), 64'd0);
            chk($sformatf("rst_data[%0d]", m), rd_data_o[m], 64'd0);
            chk($sformatf("rst_err[%0d]", m), 64'({err_rd_o[m], err_wr_o[m]}), 64'd0);
            chk($sformatf("rst_stat[%0d]", m), stat_rd_o[m] | 64'(stat_wr_o[m]), 64'd0);
        end
        nv = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            for (int m = 0; m < NI; m++) nv += int'(rd_valid_o[m][0]) + int'(rd_valid_o[m][1]);
        end
        chk("rst_dropped_valids", 64'(nv), 64'd0);
        read_watch("rst_mem_kept", 1, 11'd5, 32'hDEADBEEF, 32'hDEADBEEF);

        // Throughput: fresh counters, 100 back-to-back reads on both ports
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < NI*NP; i++) begin vcnt[i] = 0; first_v[i] = -1; last_v[i] = -1; end
        for (int n = 0; n < 104; n++) begin
            if (n < 100) begin
                rd_en = 2'b11;
                rd_addr[0 +: AW]  = AW'(n % 64);
                rd_addr[AW +: AW] = AW'(n % 64);
            end else begin
                idle();
            end
            step();
            for (int m = 0; m < NI; m++) begin
                for (int p = 0; p < NP; p++) begin
                    if (rd_valid_o[m][p]) begin
                        vcnt[m*NP+p]++;
                        if (first_v[m*NP+p] < 0) first_v[m*NP+p] = n;
                        last_v[m*NP+p] = n;
                    end
                end
            end
        end
        idle();
        for (int m = 0; m < NI; m++) begin
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("thr_count[%0d][%0d]", m, p), 64'(vcnt[m*NP+p]), 64'd100);
                chk($sformatf("thr_span[%0d][%0d]", m, p), 64'(last_v[m*NP+p] - first_v[m*NP+p]), 64'd99);
`ifdef MEMREF_MP_STATS_EN
                chk($sformatf("thr_stat[%0d][%0d]", m, p), 64'(stat_rd_o[m][p*32 +: 32]), 64'd100);
`else
                chk($sformatf("thr_stat[%0d][%0d]", m, p), 64'(stat_rd_o[m][p*32 +: 32]), 64'd0);
`endif
            end
        end

        // Randomized traffic with forced collisions and occasional resets
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(63) != 0);
            rd_en   = NP'($urandom);
            wr_en   = 1'($urandom_range(1));
            wr_be   = 4'($urandom);
            wr_addr = rand_addr();
            wr_data = $urandom;
            err_clr = ($urandom_range(15) == 0);
            for (int p = 0; p < NP; p++) begin
                rd_addr[p*AW +: AW] = ($urandom_range(3) == 0) ? wr_addr : rand_addr();
            end
            step();
        end
        rst = 1'b1;
        idle();
        for (int n = 0; n < 5; n++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
